// File: rtl/mms_verify_respond_if.sv
// mms_verify_respond_if: mPacket request/completion and receive-pulse bundle
// between the MAC merge verify/respond block and its neighbours.
//   slave  : the verify/respond block (consumes pulses, drives requests)
//   master : environment (rx classifier + tx arbiter side)
interface mms_verify_respond_if;
  logic rcv_v;   // valid verify mPacket received (1-cycle pulse)
  logic rcv_r;   // valid respond mPacket received (1-cycle pulse)
  logic v_sent;  // requested verify mPacket transmitted (1-cycle pulse)
  logic r_sent;  // requested respond mPacket transmitted (1-cycle pulse)
  logic send_v;  // verify mPacket request (level)
  logic send_r;  // respond mPacket request (level)

  modport master (
    output rcv_v, rcv_r, v_sent, r_sent,
    input  send_v, send_r
  );

  modport slave (
    input  rcv_v, rcv_r, v_sent, r_sent,
    output send_v, send_r
  );
endinterface

// File: rtl/mms_verify_respond.sv
// mms_verify_respond: 802.3br MAC merge verify machine plus respond machine.
// The verify machine sends up to VERIFY_LIMIT verify mPackets, each followed
// by a VERIFY_TIME_CYC-cycle response window, and reports the outcome. The
// respond machine answers received verify mPackets, independent of verify.
// All outputs are registered and decoded from the next state.
// Optional build macro MMS_VERIFY_STATS_EN adds three saturating 16-bit
// transmit/failure counters as extra outputs.
module mms_verify_respond #(
  parameter int unsigned VERIFY_TIME_CYC = 10000,
  parameter int unsigned VERIFY_LIMIT    = 3,
  parameter int unsigned TIMER_W         = 24
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       p_enable,
  input  logic                       disable_verify,
  input  logic                       link_fail,
  mms_verify_respond_if.slave        bus,
  output logic [2:0]                 verify_status,
  output logic [3:0]                 verify_cnt,
  output logic                       preempt_active
`ifdef MMS_VERIFY_STATS_EN
  ,
  output logic [15:0]                stat_verify_tx,
  output logic [15:0]                stat_respond_tx,
  output logic [15:0]                stat_verify_fail
`endif
);

  typedef enum logic [2:0] {
    V_INIT     = 3'd0,
    V_SEND     = 3'd1,
    V_WAIT     = 3'd2,
    V_VERIFIED = 3'd3,
    V_FAIL     = 3'd4,
    V_DISABLED = 3'd5
  } vstate_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_SEND = 1'b1
  } rstate_e;

  localparam logic [2:0] ST_UNKNOWN   = 3'd0;
  localparam logic [2:0] ST_INITIAL   = 3'd1;
  localparam logic [2:0] ST_VERIFYING = 3'd2;
  localparam logic [2:0] ST_SUCCEEDED = 3'd3;
  localparam logic [2:0] ST_FAILED    = 3'd4;
  localparam logic [2:0] ST_DISABLED  = 3'd5;

  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(VERIFY_TIME_CYC - 1);
  localparam logic [3:0]         LIMIT_C      = 4'(VERIFY_LIMIT);

  vstate_e              vstate_q, vstate_d;
  rstate_e              rstate_q, rstate_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [3:0]           vcnt_q, vcnt_d;
  logic [2:0]           status_q, status_d;
  logic                 send_v_q, send_v_d;
  logic                 send_r_q, send_r_d;
  logic                 preempt_q, preempt_d;

  logic                 restart_s;
  logic                 v_accept_s;
  logic                 r_accept_s;

  // Restart is link loss or preemption administratively off.
  assign restart_s  = link_fail | ~p_enable;
  // Completion pulses only count while the matching request is outstanding.
  assign v_accept_s = (vstate_q == V_SEND) & bus.v_sent;
  assign r_accept_s = (rstate_q == R_SEND) & bus.r_sent;

  // Verify machine next state, response timer and attempt counter.
  always_comb begin
    vstate_d = vstate_q;
    timer_d  = timer_q;
    vcnt_d   = vcnt_q;
    if (restart_s && (vstate_q != V_INIT)) begin
      vstate_d = V_INIT;
    end else begin
      case (vstate_q)
        V_INIT: begin
          if (restart_s) begin
            vstate_d = V_INIT;
          end else if (disable_verify) begin
            vstate_d = V_DISABLED;
          end else begin
            vstate_d = V_SEND;
          end
        end
        V_SEND: begin
          if (disable_verify) begin
            vstate_d = V_INIT;
          end else if (v_accept_s) begin
            vstate_d = V_WAIT;
            timer_d  = TIMER_RELOAD;
            vcnt_d   = vcnt_q + 4'd1;
          end else begin
            vstate_d = V_SEND;
          end
        end
        V_WAIT: begin
          if (disable_verify) begin
            vstate_d = V_INIT;
          end else if (bus.rcv_r) begin
            vstate_d = V_VERIFIED;
          end else if (timer_q == '0) begin
            if (vcnt_q < LIMIT_C) begin
              vstate_d = V_SEND;
            end else begin
              vstate_d = V_FAIL;
            end
          end else begin
            timer_d = timer_q - {{(TIMER_W-1){1'b0}}, 1'b1};
          end
        end
        V_VERIFIED: begin
          if (disable_verify) begin
            vstate_d = V_DISABLED;
          end else begin
            vstate_d = V_VERIFIED;
          end
        end
        V_FAIL: begin
          vstate_d = V_FAIL;
        end
        V_DISABLED: begin
          if (!disable_verify) begin
            vstate_d = V_INIT;
          end else begin
            vstate_d = V_DISABLED;
          end
        end
        default: begin
          vstate_d = V_INIT;
        end
      endcase
    end
    // Every entry into INIT starts a fresh round.
    if (vstate_d == V_INIT) begin
      vcnt_d  = 4'd0;
      timer_d = '0;
    end else begin
      vcnt_d  = vcnt_d;
    end
  end

  // Respond machine next state: coalesces repeated rcv_v while pending.
  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE: begin
        if (bus.rcv_v && p_enable) begin
          rstate_d = R_SEND;
        end else begin
          rstate_d = R_IDLE;
        end
      end
      R_SEND: begin
        if (!p_enable) begin
          rstate_d = R_IDLE;
        end else if (r_accept_s) begin
          rstate_d = bus.rcv_v ? R_SEND : R_IDLE;
        end else begin
          rstate_d = R_SEND;
        end
      end
      default: begin
        rstate_d = R_IDLE;
      end
    endcase
  end

  // Output decode from next state so every output is a register.
  always_comb begin
    status_d = ST_UNKNOWN;
    case (vstate_d)
      V_INIT:     status_d = ST_INITIAL;
      V_SEND:     status_d = ST_VERIFYING;
      V_WAIT:     status_d = ST_VERIFYING;
      V_VERIFIED: status_d = ST_SUCCEEDED;
      V_FAIL:     status_d = ST_FAILED;
      V_DISABLED: status_d = ST_DISABLED;
      default:    status_d = ST_UNKNOWN;
    endcase
    send_v_d  = (vstate_d == V_SEND);
    send_r_d  = (rstate_d == R_SEND);
    preempt_d = p_enable & ((status_d == ST_SUCCEEDED) | (status_d == ST_DISABLED));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vstate_q  <= V_INIT;
      rstate_q  <= R_IDLE;
      timer_q   <= '0;
      vcnt_q    <= 4'd0;
      status_q  <= ST_UNKNOWN;
      send_v_q  <= 1'b0;
      send_r_q  <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      vstate_q  <= vstate_d;
      rstate_q  <= rstate_d;
      timer_q   <= timer_d;
      vcnt_q    <= vcnt_d;
      status_q  <= status_d;
      send_v_q  <= send_v_d;
      send_r_q  <= send_r_d;
      preempt_q <= preempt_d;
    end
  end

  assign bus.send_v     = send_v_q;
  assign bus.send_r     = send_r_q;
  assign verify_status  = status_q;
  assign verify_cnt     = vcnt_q;
  assign preempt_active = preempt_q;

`ifdef MMS_VERIFY_STATS_EN
  logic [15:0] stat_vtx_q;
  logic [15:0] stat_rtx_q;
  logic [15:0] stat_vfail_q;
  logic        fail_entry_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  assign fail_entry_s = (vstate_d == V_FAIL) & (vstate_q != V_FAIL);

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_vtx_q   <= 16'd0;
      stat_rtx_q   <= 16'd0;
      stat_vfail_q <= 16'd0;
    end else begin
      if (v_accept_s) begin
        stat_vtx_q <= sat_inc(stat_vtx_q);
      end
      if (r_accept_s) begin
        stat_rtx_q <= sat_inc(stat_rtx_q);
      end
      if (fail_entry_s) begin
        stat_vfail_q <= sat_inc(stat_vfail_q);
      end
    end
  end

  assign stat_verify_tx   = stat_vtx_q;
  assign stat_respond_tx  = stat_rtx_q;
  assign stat_verify_fail = stat_vfail_q;
`endif

endmodule

// File: tb/tb_mms_verify_respond.sv
// tb_mms_verify_respond: directed-vector bench for mms_verify_respond with
// VERIFY_TIME_CYC=8, VERIFY_LIMIT=3. Inputs change and outputs are sampled
// on the falling clock edge; a pulse is high across exactly one rising edge.
module tb_mms_verify_respond;

  logic        clk;
  logic        reset_n;
  logic        p_enable;
  logic        disable_verify;
  logic        link_fail;
  logic [2:0]  verify_status;
  logic [3:0]  verify_cnt;
  logic        preempt_active;
`ifdef MMS_VERIFY_STATS_EN
  logic [15:0] stat_verify_tx;
  logic [15:0] stat_respond_tx;
  logic [15:0] stat_verify_fail;
`endif

  int n_checks;
  int n_pass;

  mms_verify_respond_if bus ();

  mms_verify_respond #(
    .VERIFY_TIME_CYC (8),
    .VERIFY_LIMIT    (3),
    .TIMER_W         (24)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .p_enable         (p_enable),
    .disable_verify   (disable_verify),
    .link_fail        (link_fail),
    .bus              (bus.slave),
    .verify_status    (verify_status),
    .verify_cnt       (verify_cnt),
    .preempt_active   (preempt_active)
`ifdef MMS_VERIFY_STATS_EN
    ,
    .stat_verify_tx   (stat_verify_tx),
    .stat_respond_tx  (stat_respond_tx),
    .stat_verify_fail (stat_verify_fail)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_status"},  32'(verify_status), 32'd0);
    check_eq({tag, "_cnt"},     32'(verify_cnt), 32'd0);
    check_eq({tag, "_send_v"},  32'(bus.send_v), 32'd0);
    check_eq({tag, "_send_r"},  32'(bus.send_r), 32'd0);
    check_eq({tag, "_preempt"}, 32'(preempt_active), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n = 1'b0; p_enable = 1'b0; disable_verify = 1'b0; link_fail = 1'b0;
    bus.rcv_v = 1'b0; bus.rcv_r = 1'b0; bus.v_sent = 1'b0; bus.r_sent = 1'b0;
    tick(2);
    check_all_zero("reset");

    // Leave reset with p_enable low: INIT is visible as status 1.
    reset_n = 1'b1;
    tick(1);
    check_eq("init_status", 32'(verify_status), 32'd1);
    check_eq("init_send_v", 32'(bus.send_v), 32'd0);

    // Successful verify on the first attempt.
    p_enable = 1'b1;
    tick(1);
    check_eq("send_status", 32'(verify_status), 32'd2);
    check_eq("send_send_v", 32'(bus.send_v), 32'd1);
    tick(2);
    bus.v_sent = 1'b1; tick(1); bus.v_sent = 1'b0;
    check_eq("wait_send_v", 32'(bus.send_v), 32'd0);
    check_eq("wait_cnt", 32'(verify_cnt), 32'd1);
    check_eq("wait_status", 32'(verify_status), 32'd2);
    tick(4);
    bus.rcv_r = 1'b1; tick(1); bus.rcv_r = 1'b0;
    check_eq("ok_status", 32'(verify_status), 32'd3);
    check_eq("ok_preempt", 32'(preempt_active), 32'd1);
    check_eq("ok_cnt", 32'(verify_cnt), 32'd1);

    // v_sent without an outstanding request is ignored.
    bus.v_sent = 1'b1; tick(1); bus.v_sent = 1'b0;
    check_eq("stray_vsent_cnt", 32'(verify_cnt), 32'd1);
    check_eq("stray_vsent_status", 32'(verify_status), 32'd3);

    // One-cycle link failure restarts verification.
    link_fail = 1'b1; tick(1); link_fail = 1'b0;
    check_eq("lf_status", 32'(verify_status), 32'd1);
    check_eq("lf_cnt", 32'(verify_cnt), 32'd0);
    check_eq("lf_send_v", 32'(bus.send_v), 32'd0);
    check_eq("lf_preempt", 32'(preempt_active), 32'd0);
    tick(1);
    check_eq("lf_resend", 32'(bus.send_v), 32'd1);

    // rcv_r while in SEND_VERIFY is not latched.
    bus.rcv_r = 1'b1; tick(1); bus.rcv_r = 1'b0;
    check_eq("early_rcvr_status", 32'(verify_status), 32'd2);

    // Three unanswered attempts, 8-cycle windows each, then FAILED.
    for (int a = 1; a <= 3; a++) begin
      check_eq("att_send_v", 32'(bus.send_v), 32'd1);
      bus.v_sent = 1'b1; tick(1); bus.v_sent = 1'b0;
      check_eq("att_cnt", 32'(verify_cnt), 32'(a));
      check_eq("att_send_v_low", 32'(bus.send_v), 32'd0);
      tick(7);
      check_eq("att_window_send_v", 32'(bus.send_v), 32'd0);
      check_eq("att_window_status", 32'(verify_status), 32'd2);
      tick(1);
    end
    check_eq("fail_status", 32'(verify_status), 32'd4);
    check_eq("fail_cnt", 32'(verify_cnt), 32'd3);
    check_eq("fail_preempt", 32'(preempt_active), 32'd0);
    check_eq("fail_send_v", 32'(bus.send_v), 32'd0);
`ifdef MMS_VERIFY_STATS_EN
    check_eq("stat_vfail", 32'(stat_verify_fail), 32'd1);
    check_eq("stat_vtx", 32'(stat_verify_tx), 32'd4);
`endif
    tick(3);
    check_eq("fail_hold", 32'(verify_status), 32'd4);

    // rcv_r in the expiry cycle of the last attempt wins.
    link_fail = 1'b1; tick(1); link_fail = 1'b0;
    tick(1);
    for (int a = 1; a <= 3; a++) begin
      bus.v_sent = 1'b1; tick(1); bus.v_sent = 1'b0;
      tick(7);
      if (a < 3) begin
        tick(1);
      end else begin
        bus.rcv_r = 1'b1; tick(1); bus.rcv_r = 1'b0;
      end
    end
    check_eq("edge_status", 32'(verify_status), 32'd3);
    check_eq("edge_cnt", 32'(verify_cnt), 32'd3);
    check_eq("edge_preempt", 32'(preempt_active), 32'd1);

    // Respond machine: overlap, release, coalescing.
    bus.rcv_v = 1'b1; tick(1); bus.rcv_v = 1'b0;
    check_eq("rsp_req", 32'(bus.send_r), 32'd1);
    bus.rcv_v = 1'b1; bus.r_sent = 1'b1; tick(1); bus.rcv_v = 1'b0; bus.r_sent = 1'b0;
    check_eq("rsp_overlap", 32'(bus.send_r), 32'd1);
    bus.r_sent = 1'b1; tick(1); bus.r_sent = 1'b0;
    check_eq("rsp_done", 32'(bus.send_r), 32'd0);
    bus.rcv_v = 1'b1; tick(1); bus.rcv_v = 1'b0;
    tick(1);
    bus.rcv_v = 1'b1; tick(1); bus.rcv_v = 1'b0;
    check_eq("rsp_coalesce_req", 32'(bus.send_r), 32'd1);
    bus.r_sent = 1'b1; tick(1); bus.r_sent = 1'b0;
    check_eq("rsp_coalesce_done", 32'(bus.send_r), 32'd0);
    tick(2);
    check_eq("rsp_no_extra", 32'(bus.send_r), 32'd0);

    // disable_verify during WAIT_FOR_RESPONSE returns to INIT, then DISABLED.
    link_fail = 1'b1; tick(1); link_fail = 1'b0;
    tick(1);
    bus.v_sent = 1'b1; tick(1); bus.v_sent = 1'b0;
    tick(2);
    disable_verify = 1'b1; tick(1);
    check_eq("dis_wait_status", 32'(verify_status), 32'd1);
    check_eq("dis_wait_send_v", 32'(bus.send_v), 32'd0);
    tick(1);
    check_eq("dis_status", 32'(verify_status), 32'd5);
    check_eq("dis_preempt", 32'(preempt_active), 32'd1);
    disable_verify = 1'b0; tick(1);
    check_eq("undis_status", 32'(verify_status), 32'd1);
    tick(1);
    check_eq("undis_send", 32'(verify_status), 32'd2);

    // Asynchronous reset in the middle of WAIT_FOR_RESPONSE.
    bus.v_sent = 1'b1; tick(1); bus.v_sent = 1'b0;
    bus.rcv_v = 1'b1; tick(1); bus.rcv_v = 1'b0;
    tick(1);
    check_eq("pre_rst_send_r", 32'(bus.send_r), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_rst");

    // disable_verify held from reset: straight to DISABLED, never sends.
    disable_verify = 1'b1;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check_eq("dis_rst_status", 32'(verify_status), 32'd5);
    check_eq("dis_rst_preempt", 32'(preempt_active), 32'd1);
    check_eq("dis_rst_send_v", 32'(bus.send_v), 32'd0);
    tick(3);
    check_eq("dis_rst_hold_send_v", 32'(bus.send_v), 32'd0);
    check_eq("dis_rst_hold_status", 32'(verify_status), 32'd5);

`ifdef MMS_VERIFY_STATS_EN
    // Respond counter saturates after more than 65535 completions.
    bus.rcv_v = 1'b1; bus.r_sent = 1'b1;
    tick(70000);
    bus.rcv_v = 1'b0; bus.r_sent = 1'b0;
    tick(1);
    check_eq("stat_rtx_sat", 32'(stat_respond_tx), 32'h0000FFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mms_verify_respond.md
Name: mms_verify_respond

Overview:
- Synthesisable, clocked successor to the MAC merge respond-only machine. Combines the 802.3br verify machine (Fig 99-8) and respond machine (Fig 99-8b) in one block.
- Timeout and attempt limit are parametrised.
- Sits between MAC merge receive/express-frame classification and the MAC merge transmit arbiter. Requests verify/respond mPackets, consumes their completion pulses, and reports verification status and preemption enable.

Parameters:
- VERIFY_TIME_CYC, 10000, clock cycles per verifyTime window (must be >= 2)
- VERIFY_LIMIT, 3, verify attempts before declaring FAILED (1..15)
- TIMER_W, 24, timer width in bits; must hold VERIFY_TIME_CYC

Ports:
- clk  in  1  block clock
- reset_n  in  1  asynchronous active-low reset
- p_enable  in  1  pEnable, preemption administratively enabled (level)
- disable_verify  in  1  verification disabled by management (level)
- link_fail  in  1  link down (level)
- rcv_v  in  1  one-cycle pulse: valid verify mPacket received
- rcv_r  in  1  one-cycle pulse: valid respond mPacket received
- v_sent  in  1  one-cycle pulse: requested verify mPacket fully transmitted
- r_sent  in  1  one-cycle pulse: requested respond mPacket fully transmitted
- send_v  out  1  verify mPacket request (level, held until v_sent)
- send_r  out  1  respond mPacket request (level, held until r_sent)
- verify_status  out  3  0 UNKNOWN, 1 INITIAL, 2 VERIFYING, 3 SUCCEEDED, 4 FAILED, 5 DISABLED
- verify_cnt  out  4  verify attempts made in the current round
- preempt_active  out  1  p_enable & (status==SUCCEEDED | status==DISABLED)

Behaviour:
- Reset (async assert, sync release):
  - verify state INIT_VERIFICATION, respond state RESPOND_IDLE
  - send_v=0, send_r=0, verify_status=0, verify_cnt=0, timer=0, preempt_active=0
- All outputs are registered. State change is visible the cycle after the qualifying input.
- Restart condition R = link_fail | !p_enable. In any verify state other than INIT_VERIFICATION, R forces INIT_VERIFICATION next cycle and drops send_v. R has priority over every other verify transition.
- Verify machine:
  - INIT_VERIFICATION:
    - status=1, verify_cnt=0, send_v=0
    - if !R & disable_verify -> VERIFY_DISABLED
    - if !R & !disable_verify -> SEND_VERIFY
  - SEND_VERIFY:
    - send_v=1, status=2
    - on v_sent: send_v=0, timer=VERIFY_TIME_CYC-1, verify_cnt+1 -> WAIT_FOR_RESPONSE
  - WAIT_FOR_RESPONSE:
    - timer decrements each cycle
    - rcv_r -> VERIFIED
    - timer==0 & !rcv_r & verify_cnt<VERIFY_LIMIT -> SEND_VERIFY
    - timer==0 & !rcv_r & verify_cnt==VERIFY_LIMIT -> VERIFY_FAIL
    - rcv_r in the expiry cycle wins (VERIFIED)
  - VERIFIED: status=3; held until R, or disable_verify -> VERIFY_DISABLED.
  - VERIFY_FAIL: status=4; held until R.
  - VERIFY_DISABLED: status=5; on !disable_verify -> INIT_VERIFICATION.
  - disable_verify asserted in SEND_VERIFY or WAIT_FOR_RESPONSE -> INIT_VERIFICATION. send_v drops at the same time.
- rcv_r outside WAIT_FOR_RESPONSE is ignored and not latched.
- Respond machine (independent of verify state; gated only by p_enable):
  - RESPOND_IDLE: send_r=0; rcv_v & p_enable -> SEND_RESPOND.
  - SEND_RESPOND: send_r=1.
    - r_sent & !rcv_v -> RESPOND_IDLE
    - r_sent & rcv_v in the same cycle -> stay in SEND_RESPOND, send_r held, one further respond owed
  - Additional rcv_v while a respond is pending (without r_sent) coalesces; no extra respond is sent.
  - !p_enable in SEND_RESPOND -> RESPOND_IDLE.
- send_v and send_r may be high together; the transmit arbiter orders them. Neither machine waits on the other.
- A v_sent or r_sent pulse while the matching request is low is ignored.

Optional Feature:
- Macro MMS_VERIFY_STATS_EN.
- Defined: adds three outputs, each 16 bits, saturating at 0xFFFF, cleared only by reset:
  - stat_verify_tx (incremented on accepted v_sent)
  - stat_respond_tx (incremented on accepted r_sent)
  - stat_verify_fail (incremented on entry to VERIFY_FAIL)
- Undefined: ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then p_enable=1, disable_verify=0. Pulse v_sent 3 cycles after send_v, then rcv_r 5 cycles later. Expect status 1->2->3, verify_cnt=1, preempt_active=1 one cycle after rcv_r.
- VERIFY_TIME_CYC=8, VERIFY_LIMIT=3, v_sent always returned, no rcv_r. Expect 3 send_v requests spaced by 8-cycle waits, then status=4, verify_cnt=3, preempt_active=0.
- rcv_r in the exact cycle timer reaches 0 on the 3rd attempt -> status=3, not 4.
- In SEND_RESPOND, rcv_v and r_sent in the same cycle -> send_r stays 1. The next r_sent alone -> send_r=0. Two rcv_v pulses before any r_sent -> exactly one respond.
- In VERIFIED, link_fail=1 for 1 cycle -> status=1 next cycle, verify_cnt=0, send_v=0. Assert reset_n low mid-WAIT_FOR_RESPONSE -> all outputs 0 immediately.
- disable_verify=1 from reset -> status=5, preempt_active=1, no send_v. With MMS_VERIFY_STATS_EN, 70000 forced r_sent cycles -> stat_respond_tx=0xFFFF.
